// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with busy scoreboard and two prioritised write-back ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CW = 16,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_ready,
  output logic            rs2_ready,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  output logic            wb1_ready,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic            busy_any,
  output logic [CW-1:0]   collision_cnt
);
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      wb0_wr, wb1_wr;
  assign wb0_wr    = wb0_en && wb0_addr != '0;
  assign wb1_ready = !wb0_wr;
  assign wb1_wr    = wb1_valid && wb1_ready && wb1_addr != '0;
  // x0 is never written or reserved, so regs_q[0] and busy_q[0] stay zero
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb0_wr) begin
      regs_d[wb0_addr] = wb0_data;
      busy_d[wb0_addr] = 1'b0;
    end
    if (wb1_wr) begin
      regs_d[wb1_addr] = wb1_data;
      busy_d[wb1_addr] = 1'b0;
    end
    if (issue_en && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    cnt_d = (wb1_valid && !wb1_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  logic h01, h11, h02, h12;
  assign h01 = wb0_wr && wb0_addr == rs1_addr;
  assign h11 = wb1_wr && wb1_addr == rs1_addr;
  assign h02 = wb0_wr && wb0_addr == rs2_addr;
  assign h12 = wb1_wr && wb1_addr == rs2_addr;
  assign rs1_data  = h01 ? wb0_data : h11 ? wb1_data : regs_q[rs1_addr];
  assign rs2_data  = h02 ? wb0_data : h12 ? wb1_data : regs_q[rs2_addr];
  assign rs1_ready = h01 || h11 || !busy_q[rs1_addr];
  assign rs2_ready = h02 || h12 || !busy_q[rs2_addr];
  assign busy_any      = |busy_q;
  assign collision_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (CW=4 to reach saturation quickly).
module tb_regfile_sb;
  logic        clk = 1'b0, reset;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb0_addr, wb1_addr;
  logic [31:0] rs1_data, rs2_data, wb0_data, wb1_data;
  logic        rs1_ready, rs2_ready, issue_en, wb0_en, wb1_valid, wb1_ready, busy_any;
  logic [3:0]  collision_cnt;
  int checks = 0, errors = 0;
  regfile_sb #(.XLEN(32), .NREG(32), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready),
    .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .busy_any(busy_any), .collision_cnt(collision_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; rs1_addr = '0; rs2_addr = '0; issue_en = 1'b0; issue_rd = '0;
    wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0; wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy_any", busy_any, 0);
    chk("rst_cnt", collision_cnt, 0);
    chk("rst_wb1_ready", wb1_ready, 1);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      chk("rst_rs1_data", rs1_data, 0);
      chk("rst_rs2_data", rs2_data, 0);
      chk("rst_rs1_ready", rs1_ready, 1);
      chk("rst_rs2_ready", rs2_ready, 1);
    end
    wb0_en = 1'b1; wb0_addr = 5; wb0_data = 32'hDEADBEEF; rs1_addr = 5;
    #1 chk("wb0_bypass", rs1_data, 32'hDEADBEEF);
    tick();
    wb0_en = 1'b0;
    #1 chk("wb0_stored", rs1_data, 32'hDEADBEEF);
    wb0_en = 1'b1; wb0_addr = 0; wb0_data = 32'h1234; rs1_addr = 0;
    #1 chk("x0_bypass", rs1_data, 0);
    chk("x0_no_block", wb1_ready, 1);
    tick();
    wb0_en = 1'b0;
    #1 chk("x0_read", rs1_data, 0);
    issue_en = 1'b1; issue_rd = 7; rs2_addr = 7;
    #1 chk("issue_same_cycle_ready", rs2_ready, 1);
    tick();
    issue_en = 1'b0;
    #1 chk("issue_busy_ready", rs2_ready, 0);
    chk("issue_busy_any", busy_any, 1);
    wb1_valid = 1'b1; wb1_addr = 7; wb1_data = 32'h55;
    #1 chk("wb1_ready_free", wb1_ready, 1);
    chk("wb1_bypass_ready", rs2_ready, 1);
    chk("wb1_bypass_data", rs2_data, 32'h55);
    tick();
    wb1_valid = 1'b0;
    #1 chk("wb1_busy_any_clear", busy_any, 0);
    chk("wb1_stored", rs2_data, 32'h55);
    chk("wb1_stored_ready", rs2_ready, 1);
    wb1_valid = 1'b1; wb1_addr = 9; wb1_data = 32'hA;
    wb0_en = 1'b1; wb0_addr = 3; wb0_data = 32'h33;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", wb1_ready, 0);
      tick();
    end
    wb0_en = 1'b0; rs1_addr = 9; rs2_addr = 3;
    #1 chk("stall_cnt3", collision_cnt, 3);
    chk("stall_release", wb1_ready, 1);
    chk("stall_fire_bypass", rs1_data, 32'hA);
    chk("stall_x3", rs2_data, 32'h33);
    tick();
    wb1_valid = 1'b0;
    #1 chk("stall_x9", rs1_data, 32'hA);
    chk("stall_cnt_hold", collision_cnt, 3);
    wb0_en = 1'b1; wb0_addr = 0; wb1_valid = 1'b1; wb1_addr = 10; wb1_data = 32'hB;
    #1 chk("wb0_x0_wb1_ready", wb1_ready, 1);
    tick();
    wb0_en = 1'b0; wb1_valid = 1'b0; rs2_addr = 10;
    #1 chk("wb0_x0_wb1_x10", rs2_data, 32'hB);
    chk("wb0_x0_cnt", collision_cnt, 3);
    issue_en = 1'b1; issue_rd = 4; wb0_en = 1'b1; wb0_addr = 4; wb0_data = 32'h77;
    tick();
    issue_en = 1'b0; wb0_en = 1'b0; rs1_addr = 4;
    #1 chk("issue_wb_data", rs1_data, 32'h77);
    chk("issue_wb_ready", rs1_ready, 0);
    wb0_en = 1'b1; wb0_addr = 6; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_addr = 6; wb1_data = 32'h2; rs2_addr = 6;
    #1 chk("same_addr_wb0", rs2_data, 32'h1);
    chk("same_addr_stall", wb1_ready, 0);
    tick();
    wb0_en = 1'b0;
    #1 chk("same_addr_wb1", rs2_data, 32'h2);
    tick();
    wb1_valid = 1'b0;
    #1 chk("same_addr_final", rs2_data, 32'h2);
    chk("same_addr_cnt", collision_cnt, 4);
    wb0_en = 1'b1; wb0_addr = 3; wb0_data = 32'h99; wb1_valid = 1'b1; wb1_addr = 9; wb1_data = 32'hC;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", collision_cnt, 15);
    chk("pre_reset_busy_any", busy_any, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; wb0_en = 1'b0; wb1_valid = 1'b0; rs1_addr = 4; rs2_addr = 5;
    #1 chk("mid_reset_cnt", collision_cnt, 0);
    chk("mid_reset_busy_any", busy_any, 0);
    chk("mid_reset_x4_ready", rs1_ready, 1);
    chk("mid_reset_x4", rs1_data, 0);
    chk("mid_reset_x5", rs2_data, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
